// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared constants and width helper for the debouncer family
// Rev 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

    localparam int unsigned DEB_STABLE_CYCLES_DEFAULT = 50000;
    localparam int unsigned DEB_LONG_CYCLES_DEFAULT   = 1000000;

    localparam int unsigned DEB_STABLE_CYCLES_SIM     = 4;
    localparam int unsigned DEB_LONG_CYCLES_SIM       = 10;

    // Smallest w with 2**w >= value; a counter holding 0..N needs clog2(N+1) bits.
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              r;
        v = 1;
        r = 0;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/debounce_multi_if.sv
// ============================================================================
// debounce_multi_if : button-side bundle of the multi-channel debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_out;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_out, btn_rise, btn_fall, btn_long
    );

    modport slave (
        input  btn_in,
        output btn_out, btn_rise, btn_fall, btn_long
    );
endinterface : debounce_multi_if

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
// debounce_chan : one channel - synchroniser, stability counter, edge pulses,
//                 optional long-press detector (DEBOUNCE_LONG_PRESS_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = 16,
    parameter int LONG_CYCLES   = DEB_LONG_CYCLES_DEFAULT,
    parameter int LONG_W        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;

    // Counter only ever reads r_s2; btn_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= btn_in;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_out  <= r_s2;
                r_cnt  <= '0;
                r_rise <= r_s2;
                r_fall <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_out  = r_out;
    assign btn_rise = r_rise;
    assign btn_fall = r_fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] C_HOLD_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] C_HOLD_MAX  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] r_hcnt;
    logic              r_long;

    // Saturating at C_HOLD_MAX gives exactly one pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_out) begin
                r_hcnt <= '0;
            end else if (r_hcnt < C_HOLD_MAX) begin
                r_hcnt <= r_hcnt + 1'b1;
                r_long <= (r_hcnt == C_HOLD_LAST);
            end
        end
    end

    assign btn_long = r_long;
`else
    assign btn_long = 1'b0;
`endif

endmodule : debounce_chan

`default_nettype wire

// File: rtl/debounce_multi.sv
// ============================================================================
// debounce_multi : N_CH independent button debouncers with rise/fall pulses;
//                  long-press pulses when DEBOUNCE_LONG_PRESS_EN is defined
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = 16,
    parameter int LONG_CYCLES   = DEB_LONG_CYCLES_DEFAULT,
    parameter int LONG_W        = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    debounce_multi_if.slave        bus
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("debounce_multi: N_CH must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES must be >= 1");
    end
    if (CNT_W < clog2(longint'(STABLE_CYCLES) + 1)) begin : g_bad_cnt_w
        $error("debounce_multi: CNT_W too narrow for STABLE_CYCLES");
    end
`ifdef DEBOUNCE_LONG_PRESS_EN
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("debounce_multi: LONG_CYCLES must be >= 1");
    end
    if (LONG_W < clog2(longint'(LONG_CYCLES) + 1)) begin : g_bad_long_w
        $error("debounce_multi: LONG_W too narrow for LONG_CYCLES");
    end
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .LONG_CYCLES   (LONG_CYCLES),
            .LONG_W        (LONG_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_in   (bus.btn_in[g]),
            .btn_out  (bus.btn_out[g]),
            .btn_rise (bus.btn_rise[g]),
            .btn_fall (bus.btn_fall[g]),
            .btn_long (bus.btn_long[g])
        );
    end

endmodule : debounce_multi

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
// tb_debounce_multi : directed self-checking bench for debounce_multi
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int N_CH   = 4;
    localparam int STABLE = DEB_STABLE_CYCLES_SIM;
    localparam int LONG   = DEB_LONG_CYCLES_SIM;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debounce_multi_if #(.N_CH(N_CH)) bus ();

    debounce_multi #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (3),
        .LONG_CYCLES   (LONG),
        .LONG_W        (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ofr(input string tag, input logic [3:0] o, input logic [3:0] r,
                              input logic [3:0] f);
        check({tag, "_out"},  bus.btn_out,  o);
        check({tag, "_rise"}, bus.btn_rise, r);
        check({tag, "_fall"}, bus.btn_fall, f);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.btn_in = '0;
        #12;
        expect_ofr("por", 4'b0000, 4'b0000, 4'b0000);
        check("por_long", bus.btn_long, 4'b0000);
        tick(1);
        rst_n = 1'b1;

        // clean press on channel 0: flips on edge STABLE+2
        bus.btn_in = 4'b0001;
        tick(STABLE + 1);
        expect_ofr("press_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_ofr("press_e6", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        expect_ofr("press_e7", 4'b0001, 4'b0000, 4'b0000);

        // 3-cycle glitch on channel 1 must be rejected
        bus.btn_in[1] = 1'b1;
        tick(3);
        bus.btn_in[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            expect_ofr("glitch", 4'b0001, 4'b0000, 4'b0000);
        end

        // 4-cycle pulse on channel 1 gets through, then falls back
        bus.btn_in[1] = 1'b1;
        tick(4);
        bus.btn_in[1] = 1'b0;
        tick(1);
        expect_ofr("pulse_e5", 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        expect_ofr("pulse_e6", 4'b0011, 4'b0010, 4'b0000);
        tick(3);
        expect_ofr("pulse_e9", 4'b0011, 4'b0000, 4'b0000);
        tick(1);
        expect_ofr("pulse_e10", 4'b0001, 4'b0000, 4'b0010);
        tick(1);
        expect_ofr("pulse_e11", 4'b0001, 4'b0000, 4'b0000);

        // bounce on channel 2, then settle high
        for (int i = 0; i < 20; i++) begin
            bus.btn_in[2] = ~bus.btn_in[2];
            tick(1);
            check("bounce_quiet", {bus.btn_out[2], bus.btn_rise[2], bus.btn_fall[2]}, 3'b000);
        end
        bus.btn_in[2] = 1'b1;
        tick(STABLE + 1);
        expect_ofr("bounce_e5", 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        expect_ofr("bounce_e6", 4'b0101, 4'b0100, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            expect_ofr("bounce_hold", 4'b0101, 4'b0000, 4'b0000);
        end

        // release everything: two simultaneous falls
        bus.btn_in = 4'b0000;
        tick(STABLE + 2);
        expect_ofr("release_e6", 4'b0000, 4'b0000, 4'b0101);
        tick(4);
        expect_ofr("release_idle", 4'b0000, 4'b0000, 4'b0000);

        // concurrent press on all channels
        bus.btn_in = 4'b1111;
        tick(STABLE + 1);
        expect_ofr("conc_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_ofr("conc_e6", 4'b1111, 4'b1111, 4'b0000);

        // long press: one pulse LONG cycles after the rise, none while held
        for (int k = 1; k <= LONG + 20; k++) begin
            tick(1);
            check("long_first", bus.btn_long,
                  (k == LONG && LONG_EN) ? 32'h0000_000F : 32'h0);
        end
        bus.btn_in[3] = 1'b0;
        tick(STABLE + 2);
        expect_ofr("long_rel", 4'b0111, 4'b0000, 4'b1000);
        tick(2);
        bus.btn_in[3] = 1'b1;
        tick(STABLE + 2);
        expect_ofr("long_repress", 4'b1111, 4'b1000, 4'b0000);
        for (int k = 1; k <= LONG + 5; k++) begin
            tick(1);
            check("long_second", bus.btn_long,
                  (k == LONG && LONG_EN) ? 32'h0000_0008 : 32'h0);
        end

        // asynchronous reset mid-run with all outputs high
        #3;
        rst_n = 1'b0;
        #1;
        expect_ofr("arst_now", 4'b0000, 4'b0000, 4'b0000);
        check("arst_long", bus.btn_long, 4'b0000);
        tick(2);
        expect_ofr("arst_held", 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        tick(STABLE + 1);
        expect_ofr("post_rst_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_ofr("post_rst_e6", 4'b1111, 4'b1111, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_debounce_multi

`default_nettype wire
